exe_muldiv: RTL
===============

Name: exe_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Takes the operation code and the forwarded operands RD1/RD2 from ID/EX.
- Computes MULT/MULTU/DIV/DIVU over multiple cycles, performs MTHI/MTLO, and holds the architectural HI/LO registers.
- Raises a stall request to the hazard unit while busy, so the front of the pipeline is frozen until the result is written.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, number of iteration cycles; must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  EX holds a valid mul/div/mthi/mtlo instruction this cycle.
- md_op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- rs_val  input  WIDTH  forwarded rs operand: dividend / multiplicand / MTHI-MTLO source.
- rt_val  input  WIDTH  forwarded rt operand: divisor / multiplier.
- flush  input  1  cancels any in-flight operation.
- busy  output  1  an operation is in progress.
- stall_req  output  1  to hazard unit; equals busy, or start with md_op in 1..4 while idle.
- done  output  1  one-cycle pulse when HI/LO are written by a mul/div.
- hi  output  WIDTH  HI register (MFHI source).
- lo  output  WIDTH  LO register (MFLO source).

Behaviour:
- Reset values (async, rst=0): state IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0, internal operand registers=0.
- State IDLE:
  - start=1 with MULT..DIVU and flush=0: latch |rs|, |rt| (abs taken only for signed ops), the result-sign and remainder-sign flags, and the op; go to CALC with counter=0.
  - start=1 with MTHI: hi<=rs_val at that edge. MTLO: lo<=rs_val. Both stay in IDLE, take one cycle, and do not pulse done.
  - NOP/reserved: no effect.
- State CALC (ITER cycles):
  - MULT/MULTU: radix-2 shift-add into a 2*WIDTH accumulator.
  - DIV/DIVU: restoring division, one quotient bit per cycle.
  - Counter increments each cycle; after the counter reaches ITER-1, go to FIX.
- State FIX (1 cycle):
  - Apply sign correction. Product is negated if the sign flag is set. Quotient takes sign(rs) XOR sign(rt); remainder takes sign(rs).
  - Write hi = upper product / remainder, lo = lower product / quotient.
  - done=1 in the following cycle only; return to IDLE.
- Latency: start sampled at edge E0; busy=1 from E0 through E(ITER+1); hi/lo updated and busy=0 at E(ITER+1) (E33 at defaults); done high for the cycle after E33.
- stall_req is combinational so the issuing cycle already stalls. Hazard unit holds later instructions (including MFHI/MFLO) until busy=0.
- Division by zero (signed or unsigned): lo=all ones, hi=rs_val (original, unsigned magnitude not used). Completes with normal latency.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Arithmetic is modulo 2^(2*WIDTH) for the product; abs(0x80000000) is handled as unsigned 0x80000000.
- start while busy: ignored; op and operands are not re-latched.
- MTHI/MTLO while busy: ignored.
- flush:
  - In CALC or FIX: abort to IDLE next edge; hi/lo keep pre-operation values; done=0.
  - flush and start in the same cycle: flush wins, nothing is started or written, including MTHI/MTLO.
- Reset mid-operation: immediate return to reset values; no partial write.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once; busy high exactly 33 cycles.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then MULT on the same operands -> hi=0, lo=1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> each written in 1 cycle; done stays 0; stall_req stays 0.
- Start DIVU 100/3, assert flush at cycle 10 -> busy=0 next cycle; hi/lo unchanged from prior values; no done. Separately, start+flush in the same cycle -> no effect.
- Start MULT, drop rst at cycle 15 -> all outputs 0 immediately. Release rst, start MULTU 6*7 -> lo=42, hi=0. Also check that a second start asserted while busy is ignored.

Source files
------------

// File: rtl/exe_muldiv.sv
// rtl/exe_muldiv.sv - iterative multiply/divide unit with HI/LO registers
//
// Purpose: EX-stage MULT/MULTU/DIV/DIVU engine (one result bit per cycle),
// MTHI/MTLO handling and the architectural HI/LO registers.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      EX holds a valid mul/div/mthi/mtlo instruction
//   md_op      0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NOP
//   rs_val     dividend / multiplicand / MTHI-MTLO source
//   rt_val     divisor / multiplier
//   flush      cancels any in-flight operation
//   busy       operation in progress
//   stall_req  freeze request to the hazard unit
//   done       one-cycle pulse after HI/LO are written by a mul/div
//   hi, lo     HI/LO registers
module exe_muldiv #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             busy,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic               r_is_div;
   logic               r_neg_q;   // product sign for mul, quotient sign for div
   logic               r_neg_r;   // remainder sign (dividend sign)
   logic               r_div0;
   logic [WIDTH-1:0]   r_b;       // |rs| for mul, |rt| for div
   logic [WIDTH-1:0]   r_rs;      // original rs, returned in HI on divide-by-zero
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_done;

   logic               w_is_md;
   logic               w_is_div;
   logic               w_signed;
   logic               w_rs_neg;
   logic               w_rt_neg;
   logic [WIDTH-1:0]   w_rs_abs;
   logic [WIDTH-1:0]   w_rt_abs;
   logic [WIDTH:0]     w_msum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_dshift;
   logic [WIDTH:0]     w_dtrial;
   logic               w_qbit;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_is_md  = (md_op >= 3'd1) && (md_op <= 3'd4);
   assign w_is_div = (md_op == 3'd3) || (md_op == 3'd4);
   assign w_signed = (md_op == 3'd1) || (md_op == 3'd3);
   assign w_rs_neg = w_signed & rs_val[WIDTH-1];
   assign w_rt_neg = w_signed & rt_val[WIDTH-1];
   // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude
   assign w_rs_abs = w_rs_neg ? -rs_val : rs_val;
   assign w_rt_abs = w_rt_neg ? -rt_val : rt_val;

   // Shift-add: multiplier sits in the low half and is consumed LSB first
   assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
   assign w_mul_next = {w_msum, r_acc[WIDTH-1:1]};

   // Restoring divide: remainder in the high half, dividend shifts out of the
   // low half while quotient bits shift in behind it
   assign w_dshift   = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_dtrial   = w_dshift - {1'b0, r_b};
   assign w_qbit     = ~w_dtrial[WIDTH];
   assign w_div_next = {(w_qbit ? w_dtrial[WIDTH-1:0] : w_dshift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_qbit};

   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_div0   <= 1'b0;
         r_b      <= '0;
         r_rs     <= '0;
         r_acc    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && !flush) begin
                  if (w_is_md) begin
                     r_is_div <= w_is_div;
                     r_neg_q  <= w_rs_neg ^ w_rt_neg;
                     r_neg_r  <= w_rs_neg;
                     r_div0   <= w_is_div && (rt_val == '0);
                     r_rs     <= rs_val;
                     r_b      <= w_is_div ? w_rt_abs : w_rs_abs;
                     r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_rs_abs : w_rt_abs)};
                     r_cnt    <= '0;
                     r_state  <= S_CALC;
                  end else if (md_op == 3'd5) begin
                     r_hi <= rs_val;
                  end else if (md_op == 3'd6) begin
                     r_lo <= rs_val;
                  end
               end
            end
            S_CALC: begin
               if (flush) begin
                  r_state <= S_IDLE;
               end else begin
                  r_acc <= r_is_div ? w_div_next : w_mul_next;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CW'(ITER - 1))
                     r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_state <= S_IDLE;
               if (!flush) begin
                  r_done <= 1'b1;
                  if (!r_is_div) begin
                     r_hi <= w_prod[2*WIDTH-1:WIDTH];
                     r_lo <= w_prod[WIDTH-1:0];
                  end else if (r_div0) begin
                     r_hi <= r_rs;
                     r_lo <= '1;
                  end else begin
                     r_hi <= w_rem;
                     r_lo <= w_quo;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = (r_state != S_IDLE);
   // While idle busy is 0, so the second term only matters on the issue cycle
   assign stall_req = busy | (start & w_is_md);
   assign done      = r_done;
   assign hi        = r_hi;
   assign lo        = r_lo;

endmodule
